// File: rtl/move_tick_gen.sv
// Frame-paced step strobe generator for enemy movement, with a free-running
// Galois LFSR supplying the direction nibble sampled at each step.
module move_tick_gen #(
  parameter int          BASE_FRAMES = 4,
  parameter int          MIN_FRAMES  = 1,
  parameter logic [15:0] LFSR_INIT   = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        enable,
  input  logic        start_of_frame,
  input  logic [2:0]  level,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        timer_done,
  output logic [3:0]  random,
  output logic [7:0]  tick_count,
  output logic        busy
);

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [7:0]  RESET_PERIOD =
    8'((BASE_FRAMES > MIN_FRAMES) ? BASE_FRAMES : MIN_FRAMES);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t      state_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  frame_cnt_q;
  logic [7:0]  eff_period_q;
  logic        sof_q;
  logic        sof_rise;
  logic        timer_done_q;
  logic [3:0]  random_q;
  logic [7:0]  tick_count_q;
  logic        busy_q;

  // Signed difference so a high level clamps to MIN_FRAMES instead of wrapping.
  function automatic logic [7:0] period_for(input logic [2:0] lvl);
    int diff;
    diff = BASE_FRAMES - int'(lvl);
    if (diff < MIN_FRAMES) diff = MIN_FRAMES;
    return diff[7:0];
  endfunction

  function automatic logic [15:0] galois_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

  assign sof_rise = start_of_frame & ~sof_q;
  assign lfsr_d   = seed_load ? ((seed == 16'h0000) ? LFSR_INIT : seed)
                              : galois_next(lfsr_q);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_INIT;
      frame_cnt_q  <= '0;
      eff_period_q <= RESET_PERIOD;
      sof_q        <= 1'b0;
      timer_done_q <= 1'b0;
      random_q     <= '0;
      tick_count_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      sof_q        <= start_of_frame;
      lfsr_q       <= lfsr_d;
      timer_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q      <= 1'b0;
          frame_cnt_q <= '0;
          if (enable) state_q <= ARMED;
        end
        ARMED: begin
          if (!enable) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
          end else if (sof_rise) begin
            // The first frame only aligns the count; it never strobes.
            state_q      <= RUN;
            busy_q       <= 1'b1;
            frame_cnt_q  <= '0;
            eff_period_q <= period_for(level);
          end
        end
        RUN: begin
          if (!enable) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
          end else if (sof_rise) begin
            if (frame_cnt_q == eff_period_q - 8'd1) begin
              frame_cnt_q  <= '0;
              eff_period_q <= period_for(level);
              timer_done_q <= 1'b1;
              random_q     <= lfsr_q[3:0];
              tick_count_q <= tick_count_q + 8'd1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign timer_done = timer_done_q;
  assign random     = random_q;
  assign tick_count = tick_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_move_tick_gen.sv
// Directed bench for move_tick_gen: expected steps are queued when the frame
// pulse is driven and checked against the strobe one cycle later.
module tb_move_tick_gen;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b1;
  logic        enable = 1'b0;
  logic        start_of_frame = 1'b0;
  logic [2:0]  level = 3'd0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        timer_done;
  logic [3:0]  random;
  logic [7:0]  tick_count;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  logic [15:0] ref_lfsr;
  logic [7:0]  exp_tick = 8'd0;
  logic [11:0] sb[$];

  move_tick_gen #(
    .BASE_FRAMES(4),
    .MIN_FRAMES (1),
    .LFSR_INIT  (16'hACE1)
  ) dut (
    .CLK           (CLK),
    .RESETn        (RESETn),
    .enable        (enable),
    .start_of_frame(start_of_frame),
    .level         (level),
    .seed_load     (seed_load),
    .seed          (seed),
    .timer_done    (timer_done),
    .random        (random),
    .tick_count    (tick_count),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  // Reference Galois LFSR, mask B400, tracking seed loads.
  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      ref_lfsr <= 16'hACE1;
    else if (seed_load)
      ref_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
    else
      ref_lfsr <= {1'b0, ref_lfsr[15:1]} ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      step_clk();
      chk("quiet", timer_done, 0);
    end
  endtask

  // One frame pulse; optionally a coincident seed load and a fixed expected nibble.
  task automatic sof(input bit exp_step, input int gap, input bit with_seed, input int rnd_fix);
    logic [11:0] e;
    start_of_frame = 1'b1;
    if (with_seed) seed_load = 1'b1;
    if (exp_step) begin
      exp_tick = exp_tick + 8'd1;
      sb.push_back({exp_tick, (rnd_fix >= 0) ? 4'(rnd_fix) : ref_lfsr[3:0]});
    end
    step_clk();
    start_of_frame = 1'b0;
    seed_load = 1'b0;
    chk("strobe", timer_done, exp_step);
    if (exp_step && sb.size() > 0) begin
      e = sb.pop_front();
      chk("random", random, e[3:0]);
      chk("tick_count", tick_count, e[11:4]);
    end
    quiet(gap);
  endtask

  initial begin
    RESETn = 1'b0;
    #3;
    chk("rst_timer_done", timer_done, 0);
    chk("rst_random", random, 0);
    chk("rst_tick_count", tick_count, 0);
    chk("rst_busy", busy, 0);
    #9 RESETn = 1'b1;
    step_clk();

    // Level 0: alignment frame, then a step every 4th frame.
    enable = 1'b1;
    level  = 3'd0;
    step_clk();
    step_clk();
    chk("armed_busy", busy, 0);
    sof(0, 10, 0, -1);
    chk("run_busy", busy, 1);
    repeat (3) sof(0, 10, 0, -1);
    sof(1, 10, 0, -1);

    // Level 7 takes effect only after the next step.
    level = 3'd7;
    repeat (3) sof(0, 10, 0, -1);
    sof(1, 10, 0, -1);
    sof(1, 10, 0, -1);
    sof(1, 10, 0, -1);

    level = 3'd2;
    sof(1, 5, 0, -1);
    sof(0, 5, 0, -1);
    sof(1, 5, 0, -1);
    sof(0, 5, 0, -1);
    sof(1, 5, 0, -1);

    // Zero seed substitutes ACE1, whose low nibble is 1.
    sof(0, 3, 0, -1);
    seed = 16'h0000;
    seed_load = 1'b1;
    step_clk();
    seed_load = 1'b0;
    sof(1, 3, 0, 1);

    seed = 16'h1234;
    seed_load = 1'b1;
    step_clk();
    seed_load = 1'b0;
    quiet(7);
    sof(0, 3, 0, -1);
    sof(1, 3, 0, -1);

    // Seed load coincident with the strobing frame: nibble is pre-load.
    seed = 16'hBEEF;
    sof(0, 3, 0, -1);
    sof(1, 3, 1, -1);
    sof(0, 3, 0, -1);
    sof(1, 3, 0, -1);

    // Frame pulse stuck high counts once.
    start_of_frame = 1'b1;
    repeat (10) begin
      step_clk();
      chk("held", timer_done, 0);
    end
    start_of_frame = 1'b0;
    step_clk();
    chk("held_release", timer_done, 0);
    sof(1, 3, 0, -1);

    // Enable dropped on the frame that would strobe.
    sof(0, 3, 0, -1);
    enable = 1'b0;
    start_of_frame = 1'b1;
    step_clk();
    start_of_frame = 1'b0;
    chk("drop_strobe", timer_done, 0);
    chk("drop_busy", busy, 0);
    quiet(3);
    chk("idle_busy", busy, 0);
    enable = 1'b1;
    step_clk();
    step_clk();
    chk("rearmed_busy", busy, 0);
    sof(0, 3, 0, -1);
    chk("rerun_busy", busy, 1);
    level = 3'd0;
    sof(0, 3, 0, -1);
    sof(1, 3, 0, -1);

    // Asynchronous reset with frame_cnt at 2.
    sof(0, 3, 0, -1);
    sof(0, 3, 0, -1);
    #2 RESETn = 1'b0;
    #1;
    chk("async_timer_done", timer_done, 0);
    chk("async_random", random, 0);
    chk("async_tick_count", tick_count, 0);
    chk("async_busy", busy, 0);
    exp_tick = 8'd0;
    sb.delete();
    @(negedge CLK);
    RESETn = 1'b1;
    step_clk();
    quiet(2);
    chk("post_rst_busy", busy, 0);

    // Period 1 for 256 steps: tick_count wraps to 0.
    level = 3'd7;
    sof(0, 2, 0, -1);
    repeat (256) sof(1, 1, 0, -1);
    chk("wrap_zero", tick_count, 0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_tick_gen.md
Name: move_tick_gen

Overview:
- Produces the `timer_done` step strobe and the 4-bit `random` direction nibble consumed by the enemy movement blocks.
- Steps are counted in VGA frames (start-of-frame pulses), not raw clocks, so movement speed is tied to the display rate.
- A level input shortens the step period.
- A free-running 16-bit LFSR supplies the nibble; it can be reseeded.

Parameters:
BASE_FRAMES, 4, frames per step at level 0
MIN_FRAMES, 1, lower bound on effective frames per step
LFSR_INIT, 16'hACE1, LFSR value after reset and substitute for a zero seed

Ports:
CLK  in  1  system clock
RESETn  in  1  asynchronous active-low reset
enable  in  1  1 = generate steps; 0 = idle, no strobes
start_of_frame  in  1  one-cycle pulse from VGA controller at frame start
level  in  3  speed level; higher = fewer frames per step
seed_load  in  1  one-cycle request to load seed into LFSR
seed  in  16  LFSR seed value
timer_done  out  1  one-cycle step strobe to movement blocks
random  out  4  direction nibble; changes only in the cycle timer_done is high
tick_count  out  8  number of steps issued since reset, wraps
busy  out  1  1 when state is RUN

Behaviour:
- Reset (async, RESETn=0):
  - Outputs: timer_done=0, random=0, tick_count=0, busy=0.
  - Internal: lfsr=LFSR_INIT, frame_cnt=0, eff_period=max(BASE_FRAMES,MIN_FRAMES), state=IDLE.
- LFSR: 16-bit Galois with mask 16'hB400 (x^16+x^14+x^13+x^11+1). Shifts right every clock in every state, including IDLE.
  - If seed_load=1, the next lfsr is seed; a seed of 0 loads LFSR_INIT instead.
  - The LFSR never holds 0.
- eff_period = max(BASE_FRAMES - level, MIN_FRAMES).
  - Use signed/extended arithmetic so there is no underflow wrap: BASE_FRAMES=4, level=7 gives 1.
  - Latched when entering RUN and at every step; a level change mid-period takes effect after the next step.
- States:
  - IDLE: busy=0. enable=1 moves to ARMED next cycle.
  - ARMED: waits for the first start_of_frame, used as the alignment frame. On it: go to RUN, frame_cnt=0, latch eff_period, no strobe.
  - RUN: busy=1. On each start_of_frame:
    - If frame_cnt==eff_period-1: frame_cnt=0, issue a step.
    - Otherwise frame_cnt++.
  - enable=0 in ARMED or RUN: return to IDLE next cycle and clear frame_cnt. No strobe is issued in that cycle, even if start_of_frame coincides.
- Step issue (registered, 1-cycle latency): SOF sampled in cycle N gives timer_done=1 in cycle N+1 only. In that same cycle:
  - random = lfsr[3:0] as it was in cycle N, i.e. the pre-load value if seed_load coincides.
  - tick_count increments, wrapping 255 to 0.
- random holds its value between strobes.
- timer_done is never high for 2 consecutive cycles, because start_of_frame is a single-cycle pulse. If SOF is stuck high, only rising edges count: SOF is edge-detected internally.
- seed_load is honoured in every state and does not disturb frame_cnt or state.
- Reset mid-period discards all counts immediately. No strobe is issued after RESETn deasserts until a full ARMED + period sequence completes.

Test Plan:
- Reset, enable=1, level=0, SOF every 100 clk -> first timer_done one cycle after the 5th SOF, then one cycle after every 4th SOF; tick_count 1,2,3...; timer_done always 1 cycle wide.
- level=7 (eff_period=1) after first step -> timer_done after every SOF following the next step; level=2 -> period 2 frames after the following step.
- seed_load with seed=16'h0000 -> lfsr becomes 16'hACE1. seed=16'h1234 loaded, then N clocks -> random at the strobe equals lfsr[3:0] from a reference Galois model with mask B400.
- enable dropped coincident with the SOF that would strobe -> no timer_done, busy=0 next cycle. Re-enable -> ARMED, first strobe again after 1+eff_period SOFs.
- RESETn pulsed low mid-period (frame_cnt=2) -> all outputs 0 immediately (async). Strobe count restarts; tick_count wraps from 255 to 0 after 256 steps.
- start_of_frame held high 10 cycles -> counted as one frame only.
